wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone B4 classic arbiter.
- Shares the single memory slave between the instruction-fetch master (m0) and the load/store master (m1).
- Round-robin on contention; holds grant for the full CYC_O assertion (block/RMW cycles).
- Watchdog terminates a stalled slave access with an error to the owning master.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width; SEL width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 16, cycles of STB without ACK/ERR/RTY before watchdog error; 0 disables the watchdog.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle/strobe/write-enable.
- m0_adr_i  in  ADDR_WIDTH  master 0 address.
- m0_sel_i  in  DATA_WIDTH/8  master 0 byte selects.
- m0_dat_i  in  DATA_WIDTH  master 0 write data.
- m0_dat_o  out  DATA_WIDTH  master 0 read data.
- m0_ack_o, m0_err_o, m0_rty_o  out  1 each  master 0 terminations.
- m1_* : identical set for master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave.
- s_adr_o  out  ADDR_WIDTH  to slave.
- s_sel_o  out  DATA_WIDTH/8  to slave.
- s_dat_o  out  DATA_WIDTH  to slave.
- s_dat_i  in  DATA_WIDTH  from slave.
- s_ack_i, s_err_i, s_rty_i  in  1 each  from slave.
- grant_o  out  2  one-hot current grant (debug/perf); 00 when idle.

Behaviour:
- State machine: IDLE, GNT0, GNT1. State, last-granted bit, watchdog counter and timeout flag are registered.
- Reset (async, immediate):
  - State IDLE; last-granted = 1, so m0 wins the first tie.
  - Counter 0, timeout flag 0, grant_o = 00.
  - All s_* controls 0; all m*_ack/err/rty 0.
- IDLE transitions:
  - Only m0_cyc_i high -> GNT0.
  - Only m1_cyc_i high -> GNT1.
  - Both high -> the master not last granted.
  - Neither -> stay in IDLE.
- GNTx transitions:
  - Stay while mx_cyc_i is high.
  - On the edge where mx_cyc_i is low: go to the other master's GNT if its cyc is high, else IDLE.
  - last-granted is updated on every grant entry.
- Arbitration latency: one cycle. A master raising cyc in cycle N drives the slave from cycle N+1 at the earliest.
- Slave-side mux (combinational from state):
  - s_adr/sel/dat/we = granted master's signals.
  - s_cyc_o = granted mx_cyc_i.
  - s_stb_o = granted mx_stb_i AND NOT timeout flag.
  - In IDLE: s_cyc_o = s_stb_o = 0; data/address outputs are don't-care (drive 0).
- Master-side terminations:
  - Granted master: ack = s_ack_i, rty = s_rty_i, err = s_err_i OR timeout flag; m*_dat_o = s_dat_i.
  - Non-granted master: ack/err/rty forced 0.
- Cycle drop: a master dropping cyc mid-transfer gates the slave off combinationally that cycle. There is no ack leakage to the other master.
- Watchdog (TIMEOUT_CYCLES > 0):
  - Counter increments each cycle with s_stb_o high and no s_ack_i/s_err_i/s_rty_i.
  - Clears on any termination, on stb low, and on a grant change.
  - When the counter reaches TIMEOUT_CYCLES-1 with no termination, the timeout flag sets on the next edge. Master sees err_o = 1 from that cycle; slave stb is gated off.
  - Flag clears on the edge where the granted master's stb is low.
  - Counter width: clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- Simultaneous events:
  - Release by one master coinciding with a request from the other -> direct handover GNTx->GNTy, no IDLE bubble.
  - Late termination from the slave while the timeout flag is set is passed through OR'd. Err wins; the master must treat it as a single termination.

Test Plan:
- Single master write then read: m0 writes 0x01234567 to addr 0, sel=1111. Slave cyc rises 1 cycle after m0_cyc; m0_ack pulses once; m1 terminations stay 0. m0 then reads addr 0: m0_dat_o = 0x01234567.
- Simultaneous request after reset: both cyc rise in the same cycle -> grant_o = 01 first. m0 releases -> grant_o = 10 on the next edge with no IDLE cycle. m1 reads addr 0 and gets 0x01234567.
- Round-robin fairness: both masters hold continuous back-to-back requests for 6 transactions -> grants alternate 01,10,01,10..., none starved.
- Held cycle: m1 keeps cyc high across 3 stb/ack transfers (write 0xDEADBEEF to addr 4, read addr 4, write 0x000000FF sel=0001 to addr 8) while m0 requests. m0 is not granted until m1 drops cyc; the readback is 0xDEADBEEF.
- Watchdog: stub slave never acks, TIMEOUT_CYCLES=4 -> m0_err_o high in the 5th cycle of stb and s_stb_o low. Flag clears after m0 drops stb; the next transfer completes normally.
- Reset mid-transfer: assert rst_i while GNT1 with stb high -> s_cyc_o/s_stb_o and grant_o go to 0 immediately (before the next edge). After release, m0 wins the first tie.

Source files
------------

// File: rtl/wb_arbiter2.sv
// wb_arbiter2 -- two-master, one-slave Wishbone B4 classic arbiter.
//
// Shares one slave between the instruction-fetch master (m0) and the
// load/store master (m1). Contention is resolved round-robin. A grant is held
// for as long as the owning master keeps CYC high, so block and RMW cycles
// are never split. A watchdog ends a stalled access with an error to the
// owning master. The watchdog is disabled when TIMEOUT_CYCLES is 0.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), async active-high reset
//   m0_* / m1_*               master-side Wishbone slave ports
//                             (cyc/stb/we/adr/sel/dat in; dat/ack/err/rty out)
//   s_*                       slave-side Wishbone master port
//   grant_o                   one-hot current grant (01 = m0, 10 = m1, 00 idle)
module wb_arbiter2 #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // master 0
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic                    m0_rty_o,
  // master 1
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    m1_rty_o,
  // slave
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  // debug / performance
  output logic [1:0]              grant_o
);

  // Counter holds 0..TIMEOUT_CYCLES; kept 1 bit wide when the watchdog is off.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] C_LIM = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [CW-1:0] C_MAX = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 0);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last;      // 1: m1 was granted last, 0: m0 was
  logic            w_last_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_to;        // watchdog fired for the current access
  logic            w_to_nxt;
  logic            w_gstb;      // granted master's strobe, qualified by its cyc
  logic            w_term;
  logic            w_gnt_chg;

  assign w_term    = s_ack_i | s_err_i | s_rty_i;
  assign w_gnt_chg = (w_state_nxt != r_state);

  // Next grant and last-granted tracking.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          // Tie: the master that was not served last wins.
          w_state_nxt = r_last ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          w_state_nxt = GNT0;
        end else if (m1_cyc_i) begin
          w_state_nxt = GNT1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GNT0: begin
        if (m0_cyc_i) begin
          w_state_nxt = GNT0;
        end else if (m1_cyc_i) begin
          w_state_nxt = GNT1;   // direct handover, no idle bubble
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GNT1: begin
        if (m1_cyc_i) begin
          w_state_nxt = GNT1;
        end else if (m0_cyc_i) begin
          w_state_nxt = GNT0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if ((w_state_nxt == GNT0) && (r_state != GNT0)) begin
      w_last_nxt = 1'b0;
    end else if ((w_state_nxt == GNT1) && (r_state != GNT1)) begin
      w_last_nxt = 1'b1;
    end else begin
      w_last_nxt = r_last;
    end
  end

  // Slave-side mux and master-side termination routing, driven from the grant.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    grant_o  = 2'b00;
    w_gstb   = 1'b0;
    case (r_state)
      GNT0: begin
        // Dropping cyc removes the master from the slave in the same cycle.
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_cyc_i & m0_stb_i & ~r_to;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_dat_o  = m0_dat_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | r_to;
        m0_rty_o = s_rty_i;
        grant_o  = 2'b01;
        w_gstb   = m0_cyc_i & m0_stb_i;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_cyc_i & m1_stb_i & ~r_to;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_dat_o  = m1_dat_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | r_to;
        m1_rty_o = s_rty_i;
        grant_o  = 2'b10;
        w_gstb   = m1_cyc_i & m1_stb_i;
      end
      default: begin
        grant_o = 2'b00;
      end
    endcase
  end

  // Watchdog: count unanswered strobe cycles and raise the timeout flag.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_to_nxt  = r_to;
    if (TIMEOUT_CYCLES == 0) begin
      w_cnt_nxt = '0;
      w_to_nxt  = 1'b0;
    end else begin
      if (w_gnt_chg || !s_stb_o || w_term) begin
        w_cnt_nxt = '0;
      end else if (r_cnt != C_MAX) begin
        w_cnt_nxt = r_cnt + C_ONE;
      end else begin
        w_cnt_nxt = r_cnt;   // saturate
      end

      // The flag gates the slave strobe off, so it is held until the
      // master withdraws its own strobe.
      if (w_gnt_chg || !w_gstb) begin
        w_to_nxt = 1'b0;
      end else if (s_stb_o && !w_term && (r_cnt == C_LIM)) begin
        w_to_nxt = 1'b1;
      end else begin
        w_to_nxt = r_to;
      end
    end
  end

  // State, last-granted, watchdog registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_to    <= w_to_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2 with a small memory slave and a
// reference model (expected memory contents, last-served master).
module tb_wb_arbiter2;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  always #5 clk = ~clk;

  logic          m_cyc [2];
  logic          m_stb [2];
  logic          m_we  [2];
  logic [AW-1:0] m_adr [2];
  logic [SW-1:0] m_sel [2];
  logic [DW-1:0] m_dat [2];

  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m0_err_o, m0_rty_o;
  logic          m1_ack_o, m1_err_o, m1_rty_o;

  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [SW-1:0] s_sel;
  logic [DW-1:0] s_dat_w;
  logic [DW-1:0] s_dat_rd;
  logic          s_ack;
  logic          s_err;
  logic          s_rty;
  logic [1:0]    grant_o;

  logic          slv_en;
  logic          mem_clr;
  logic [DW-1:0] slv_mem [0:15];

  logic [DW-1:0] exp_mem [0:15];
  int            model_last;   // index of the master served last
  int            n_tests = 0;
  int            n_fail  = 0;

  wb_arbiter2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
    .m0_adr_i(m_adr[0]), .m0_sel_i(m_sel[0]), .m0_dat_i(m_dat[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
    .m1_adr_i(m_adr[1]), .m1_sel_i(m_sel[1]), .m1_dat_i(m_dat[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_sel_o(s_sel), .s_dat_o(s_dat_w), .s_dat_i(s_dat_rd),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant_o)
  );

  // Slave: registered single-cycle ack, read data sampled before the write.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack    <= 1'b0;
      s_dat_rd <= '0;
    end else if (s_cyc && s_stb && !s_ack && slv_en) begin
      s_ack    <= 1'b1;
      s_dat_rd <= slv_mem[s_adr[5:2]];
    end else begin
      s_ack <= 1'b0;
    end
  end

  // Slave memory array.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) slv_mem[i] <= '0;
    end else if (!rst && s_cyc && s_stb && !s_ack && slv_en && s_we) begin
      for (int b = 0; b < SW; b++)
        if (s_sel[b]) slv_mem[s_adr[5:2]][8*b +: 8] <= s_dat_w[8*b +: 8];
    end
  end

  function automatic logic t_ack(input int m);
    return (m == 0) ? m0_ack_o : m1_ack_o;
  endfunction
  function automatic logic t_err(input int m);
    return (m == 0) ? m0_err_o : m1_err_o;
  endfunction
  function automatic logic t_any(input int m);
    return (m == 0) ? (m0_ack_o | m0_err_o | m0_rty_o) : (m1_ack_o | m1_err_o | m1_rty_o);
  endfunction
  function automatic logic [DW-1:0] t_dat(input int m);
    return (m == 0) ? m0_dat_o : m1_dat_o;
  endfunction
  function automatic logic [1:0] onehot(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] sel);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One strobe on master m (cyc must already be high); reports what it saw.
  task automatic xfer(input int m, input logic we, input logic [AW-1:0] adr,
                      input logic [DW-1:0] dat, input logic [SW-1:0] sel,
                      output logic [DW-1:0] rdat, output logic acked,
                      output logic leak, output logic errd, output int extra);
    m_we[m] = we; m_adr[m] = adr; m_dat[m] = dat; m_sel[m] = sel; m_stb[m] = 1'b1;
    acked = 1'b0; leak = 1'b0; errd = 1'b0; extra = 0; rdat = '0;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(negedge clk);
      if (t_any(1 - m)) leak = 1'b1;
      if (t_err(m)) errd = 1'b1;
      if (t_ack(m)) begin acked = 1'b1; rdat = t_dat(m); end
    end
    @(posedge clk); #1;
    m_stb[m] = 1'b0;
    @(negedge clk);
    if (t_ack(m)) extra++;
    if (t_any(1 - m)) leak = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_clr = 1'b1; slv_en = 1'b1;
    s_err = 1'b0; s_rty = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
      m_adr[m] = '0; m_sel[m] = '0; m_dat[m] = '0;
    end
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    model_last = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant_o); end
    n_tests++; if ({s_cyc, s_stb} !== 2'b00) begin n_fail++; $display("FAIL reset_slave_ctl: got %b want 00", {s_cyc, s_stb}); end
    n_tests++; if ({t_any(0), t_any(1)} !== 2'b00) begin n_fail++; $display("FAIL reset_terms: got %b want 00", {t_any(0), t_any(1)}); end
    @(posedge clk); #1;
    rst = 1'b0; mem_clr = 1'b0;
  endtask

  task automatic test_single_master;
    logic [DW-1:0] rd; logic ok, lk, er; int ex;
    @(posedge clk); #1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_adr[0] = '0;
    m_dat[0] = 32'h01234567; m_sel[0] = 4'hF;
    @(negedge clk);
    n_tests++; if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL single_latency: s_cyc got %b want 0", s_cyc); end
    @(negedge clk);
    n_tests++; if ({s_cyc, grant_o} !== 3'b101) begin n_fail++; $display("FAIL single_grant: got %b want 101", {s_cyc, grant_o}); end
    xfer(0, 1'b1, 32'h0, 32'h01234567, 4'hF, rd, ok, lk, er, ex);
    exp_mem[0] = merge(exp_mem[0], 32'h01234567, 4'hF);
    n_tests++; if ({ok, lk, ex} !== {1'b1, 1'b0, 32'd0}) begin n_fail++; $display("FAIL single_write: ack=%b leak=%b extra=%0d want 1 0 0", ok, lk, ex); end
    @(posedge clk); #1; m_cyc[0] = 1'b0;
    @(posedge clk); #1; m_cyc[0] = 1'b1;
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, ok, lk, er, ex);
    n_tests++; if (!ok || rd !== exp_mem[0]) begin n_fail++; $display("FAIL single_read: ack=%b got %h want %h", ok, rd, exp_mem[0]); end
    @(posedge clk); #1; m_cyc[0] = 1'b0;
    model_last = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous;
    logic [DW-1:0] rd; logic ok, lk, er; int ex;
    rst = 1'b1; model_last = 1;
    @(posedge clk); #1; rst = 1'b0;
    m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    n_tests++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL simul_first: got %b want 01", grant_o); end
    @(posedge clk); #1; m_cyc[0] = 1'b0;
    @(negedge clk);
    n_tests++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL simul_hold: got %b want 01", grant_o); end
    @(negedge clk);
    n_tests++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL simul_handover: got %b want 10", grant_o); end
    xfer(1, 1'b0, 32'h0, 32'h0, 4'hF, rd, ok, lk, er, ex);
    n_tests++; if (!ok || lk || rd !== exp_mem[0]) begin n_fail++; $display("FAIL simul_m1_read: ack=%b leak=%b got %h want %h", ok, lk, rd, exp_mem[0]); end
    @(posedge clk); #1; m_cyc[1] = 1'b0;
    model_last = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin;
    logic [DW-1:0] rd, d; logic ok, lk, er, we; int ex, g, idx; logic [SW-1:0] sel;
    m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      g = (model_last == 1) ? 0 : 1;
      @(negedge clk);
      n_tests++; if (grant_o !== onehot(g)) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, grant_o, onehot(g)); end
      we = 1'($urandom_range(0, 1)); idx = $urandom_range(0, 15);
      d = $urandom; sel = SW'($urandom_range(1, 15));
      xfer(g, we, AW'(idx * 4), d, sel, rd, ok, lk, er, ex);
      if (we) exp_mem[idx] = merge(exp_mem[idx], d, sel);
      else begin
        n_tests++; if (rd !== exp_mem[idx]) begin n_fail++; $display("FAIL rr_read%0d: got %h want %h", k, rd, exp_mem[idx]); end
      end
      n_tests++; if ({ok, lk} !== 2'b10) begin n_fail++; $display("FAIL rr_term%0d: ack=%b leak=%b want 1 0", k, ok, lk); end
      model_last = g;
      @(posedge clk); #1;
      if (k == 5) begin
        m_cyc[0] = 1'b0; m_cyc[1] = 1'b0;
      end else begin
        m_cyc[g] = 1'b0;
        @(posedge clk); #1; m_cyc[g] = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_held_cycle;
    logic [DW-1:0] rd; logic ok, lk, er; int ex;
    @(posedge clk); #1; m_cyc[1] = 1'b1;
    @(posedge clk); #1; m_cyc[0] = 1'b1;
    xfer(1, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, rd, ok, lk, er, ex);
    exp_mem[1] = merge(exp_mem[1], 32'hDEADBEEF, 4'hF);
    n_tests++; if ({ok, lk, grant_o} !== 4'b1010) begin n_fail++; $display("FAIL held_wr1: ack=%b leak=%b grant=%b want 1 0 10", ok, lk, grant_o); end
    xfer(1, 1'b0, 32'h4, 32'h0, 4'hF, rd, ok, lk, er, ex);
    n_tests++; if (rd !== exp_mem[1] || grant_o !== 2'b10) begin n_fail++; $display("FAIL held_rd: got %h grant=%b want %h 10", rd, grant_o, exp_mem[1]); end
    xfer(1, 1'b1, 32'h8, 32'h000000FF, 4'b0001, rd, ok, lk, er, ex);
    exp_mem[2] = merge(exp_mem[2], 32'h000000FF, 4'b0001);
    n_tests++; if ({ok, lk, grant_o} !== 4'b1010) begin n_fail++; $display("FAIL held_wr2: ack=%b leak=%b grant=%b want 1 0 10", ok, lk, grant_o); end
    @(posedge clk); #1; m_cyc[1] = 1'b0;
    @(posedge clk); @(negedge clk);
    n_tests++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL held_release: got %b want 01", grant_o); end
    xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, rd, ok, lk, er, ex);
    n_tests++; if (!ok || rd !== exp_mem[2]) begin n_fail++; $display("FAIL held_m0_read: ack=%b got %h want %h", ok, rd, exp_mem[2]); end
    @(posedge clk); #1; m_cyc[0] = 1'b0;
    model_last = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [DW-1:0] rd, d; logic ok, lk, er, we; int ex, p, w, idx; logic [SW-1:0] sel;
    for (int it = 0; it < 12; it++) begin
      p = $urandom_range(1, 3);
      m_cyc[0] = p[0]; m_cyc[1] = p[1];
      if (p == 3) w = (model_last == 1) ? 0 : 1;
      else w = (p == 1) ? 0 : 1;
      @(posedge clk);
      for (int h = 0; h < ((p == 3) ? 2 : 1); h++) begin
        @(negedge clk);
        n_tests++; if (grant_o !== onehot(w)) begin n_fail++; $display("FAIL rand_grant%0d_%0d: got %b want %b", it, h, grant_o, onehot(w)); end
        we = 1'($urandom_range(0, 1)); idx = $urandom_range(0, 15);
        d = $urandom; sel = SW'($urandom_range(1, 15));
        xfer(w, we, AW'(idx * 4), d, sel, rd, ok, lk, er, ex);
        if (we) exp_mem[idx] = merge(exp_mem[idx], d, sel);
        else begin
          n_tests++; if (rd !== exp_mem[idx]) begin n_fail++; $display("FAIL rand_read%0d: got %h want %h", it, rd, exp_mem[idx]); end
        end
        n_tests++; if ({ok, lk, er} !== 3'b100) begin n_fail++; $display("FAIL rand_term%0d: ack=%b leak=%b err=%b want 1 0 0", it, ok, lk, er); end
        model_last = w;
        @(posedge clk); #1; m_cyc[w] = 1'b0;
        w = 1 - w;
        if (h == 0 && p == 3) @(posedge clk);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_watchdog;
    logic [DW-1:0] rd, d; logic ok, lk, er; int ex;
    slv_en = 1'b0;
    @(posedge clk); #1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h0; m_sel[0] = 4'hF;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_tests++;
      if ({m0_err_o, s_stb, m1_err_o} !== {(c == 5), (c < 5), 1'b0}) begin
        n_fail++; $display("FAIL wd_cycle%0d: err/stb/m1err got %b want %b", c, {m0_err_o, s_stb, m1_err_o}, {(c == 5), (c < 5), 1'b0});
      end
    end
    @(posedge clk); #1; m_stb[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    n_tests++; if (m0_err_o !== 1'b0) begin n_fail++; $display("FAIL wd_clear: err got %b want 0", m0_err_o); end
    slv_en = 1'b1;
    d = $urandom;
    xfer(0, 1'b1, 32'hC, d, 4'hF, rd, ok, lk, er, ex);
    exp_mem[3] = merge(exp_mem[3], d, 4'hF);
    n_tests++; if ({ok, er} !== 2'b10) begin n_fail++; $display("FAIL wd_recover_wr: ack=%b err=%b want 1 0", ok, er); end
    xfer(0, 1'b0, 32'hC, 32'h0, 4'hF, rd, ok, lk, er, ex);
    n_tests++; if (rd !== exp_mem[3] || er !== 1'b0) begin n_fail++; $display("FAIL wd_recover_rd: got %h err=%b want %h 0", rd, er, exp_mem[3]); end
    @(posedge clk); #1; m_cyc[0] = 1'b0;
    model_last = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    slv_en = 1'b0;
    @(posedge clk); #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_adr[1] = 32'h0;
    @(posedge clk); @(negedge clk);
    n_tests++; if ({grant_o, s_stb} !== 3'b101) begin n_fail++; $display("FAIL rmid_pre: got %b want 101", {grant_o, s_stb}); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if ({grant_o, s_cyc, s_stb} !== 4'b0000) begin n_fail++; $display("FAIL rmid_async: got %b want 0000", {grant_o, s_cyc, s_stb}); end
    @(posedge clk); #1;
    rst = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0; slv_en = 1'b1; model_last = 1;
    @(posedge clk); #1;
    m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    n_tests++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL rmid_tie: got %b want 01", grant_o); end
    @(posedge clk); #1; m_cyc[0] = 1'b0; m_cyc[1] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_simultaneous();
    test_round_robin();
    test_held_cycle();
    test_random();
    test_watchdog();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
